// File: rtl/core_debug_ctrl.sv
// Debug and control satellite for the uP core.
// Exposes PC and SP on the memory map and owns the core's pause line.
// The core can be halted by a HLT, a stack dropping below a setpoint,
// a PC breakpoint or a software pause, and can be single-stepped.
module core_debug_ctrl #(
   parameter int DATA_W   = 16,
   parameter int NUM_BKPT = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [2:0]        i_memAddr,
   input  logic [DATA_W-1:0] i_memDataIn,
   input  logic              i_memWrEn,
   output logic [DATA_W-1:0] o_memDataOut,
   input  logic [DATA_W-1:0] i_reportSP,
   input  logic [DATA_W-2:0] i_reportPC,
   input  logic              i_reportHLT,
   input  logic              i_reportRetire,
   output logic              o_doPause
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      PAUSED = 2'd1,
      STEP   = 2'd2
   } DebugState;

   localparam logic [2:0] CAUSE_NONE = 3'd0;
   localparam logic [2:0] CAUSE_SW   = 3'd1;
   localparam logic [2:0] CAUSE_HLT  = 3'd2;
   localparam logic [2:0] CAUSE_OVF  = 3'd3;
   localparam logic [2:0] CAUSE_BKPT = 3'd4;
   localparam logic [2:0] CAUSE_STEP = 3'd5;

   localparam logic [2:0] BKPT_MASK = 3'((1 << NUM_BKPT) - 1);

   DebugState         state;
   DebugState         nextState;

   logic              ovfEnable;
   logic [2:0]        bkptEnable;
   logic [DATA_W-1:0] setpoint;
   logic [DATA_W-1:0] bkptAddr [3];
   logic [2:0]        haltCause;
   logic [1:0]        haltIndex;
   logic              stickyOvf;
   logic              skipBkpt;

   logic              ctrlWrite;
   logic              statusWrite;
   logic              setpointWrite;
   logic [DATA_W-1:0] pcByteAddr;
   logic              detectActive;
   logic              ovfEvent;
   logic              bkptEvent;
   logic [1:0]        bkptHitIndex;
   logic              eventHit;
   logic [2:0]        eventCause;
   logic [1:0]        eventIndex;
   logic              loadCause;
   logic [2:0]        nextCause;
   logic [1:0]        nextIndex;
   logic              leavingPause;

   assign ctrlWrite     = i_memWrEn && (i_memAddr == 3'd0);
   assign statusWrite   = i_memWrEn && (i_memAddr == 3'd1);
   assign setpointWrite = i_memWrEn && (i_memAddr == 3'd2);
   assign pcByteAddr    = {i_reportPC, 1'b0};
   assign detectActive  = (state != PAUSED);
   assign ovfEvent      = detectActive && ovfEnable && (i_reportSP < setpoint);
   assign o_doPause     = (state == PAUSED);
   assign leavingPause  = (state == PAUSED) && (nextState != PAUSED);

   // Breakpoint matching: scan from the highest slot down so that the lowest
   // matching slot is the one reported. Matching is suppressed while paused
   // and during the skip window right after leaving a pause, so resuming at
   // a breakpointed PC does not immediately trap again.
   always_comb begin
      bkptEvent    = 1'b0;
      bkptHitIndex = 2'd0;
      for (int n = NUM_BKPT - 1; n >= 0; n--) begin
         if (detectActive && !skipBkpt && bkptEnable[n] && (bkptAddr[n] == pcByteAddr)) begin
            bkptEvent    = 1'b1;
            bkptHitIndex = 2'(n);
         end
      end
   end

   // Rank the halt events of this cycle: HLT beats overflow beats breakpoint.
   // The breakpoint index is only meaningful for a breakpoint cause.
   always_comb begin
      eventHit   = 1'b1;
      eventCause = CAUSE_NONE;
      eventIndex = 2'd0;
      if (i_reportHLT) begin
         eventCause = CAUSE_HLT;
      end else if (ovfEvent) begin
         eventCause = CAUSE_OVF;
      end else if (bkptEvent) begin
         eventCause = CAUSE_BKPT;
         eventIndex = bkptHitIndex;
      end else begin
         eventHit = 1'b0;
      end
   end

   // Next-state logic. Hardware events outrank a software pause request in
   // the same cycle. A paused core stays paused while HLT is asserted; a
   // step write overrides the pause bit written alongside it. In STEP the
   // retire pulse ends the step unless a hardware event arrives first.
   always_comb begin
      nextState = state;
      loadCause = 1'b0;
      nextCause = eventCause;
      nextIndex = eventIndex;
      case (state)
         RUN: begin
            if (eventHit) begin
               nextState = PAUSED;
               loadCause = 1'b1;
            end else if (ctrlWrite && i_memDataIn[0]) begin
               nextState = PAUSED;
               loadCause = 1'b1;
               nextCause = CAUSE_SW;
               nextIndex = 2'd0;
            end
         end
         PAUSED: begin
            if (ctrlWrite && !i_reportHLT) begin
               if (i_memDataIn[2]) begin
                  nextState = STEP;
               end else if (!i_memDataIn[0]) begin
                  nextState = RUN;
               end
            end
         end
         STEP: begin
            if (eventHit) begin
               nextState = PAUSED;
               loadCause = 1'b1;
            end else if (i_reportRetire) begin
               nextState = PAUSED;
               loadCause = 1'b1;
               nextCause = CAUSE_STEP;
               nextIndex = 2'd0;
            end
         end
         default: begin
            nextState = RUN;
         end
      endcase
   end

   // Run-control state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= RUN;
      end else begin
         state <= nextState;
      end
   end

   // Halt cause and breakpoint index are captured only when a pause is
   // entered and hold until the next entry.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         haltCause <= CAUSE_NONE;
         haltIndex <= 2'd0;
      end else if (loadCause) begin
         haltCause <= nextCause;
         haltIndex <= nextIndex;
      end
   end

   // Sticky overflow flag: set by any detected overflow, even one that
   // loses priority to HLT; cleared by writing 1 to its status bit, with a
   // fresh overflow in the same cycle winning over the clear.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         stickyOvf <= 1'b0;
      end else if (ovfEvent) begin
         stickyOvf <= 1'b1;
      end else if (statusWrite && i_memDataIn[5]) begin
         stickyOvf <= 1'b0;
      end
   end

   // Breakpoint skip window: opens when the core leaves a pause and closes
   // after the first instruction retires.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         skipBkpt <= 1'b0;
      end else if (leavingPause) begin
         skipBkpt <= 1'b1;
      end else if (i_reportRetire) begin
         skipBkpt <= 1'b0;
      end
   end

   // Writable configuration: enables, setpoint and breakpoint addresses.
   // Breakpoint slots beyond NUM_BKPT never load and therefore read as 0.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ovfEnable  <= 1'b0;
         bkptEnable <= 3'd0;
         setpoint   <= '0;
         for (int n = 0; n < 3; n++) begin
            bkptAddr[n] <= '0;
         end
      end else begin
         if (ctrlWrite) begin
            ovfEnable  <= i_memDataIn[1];
            bkptEnable <= i_memDataIn[5:3] & BKPT_MASK;
         end
         if (setpointWrite) begin
            setpoint <= i_memDataIn;
         end
         for (int n = 0; n < 3; n++) begin
            if ((n < NUM_BKPT) && i_memWrEn && (i_memAddr == 3'(5 + n))) begin
               bkptAddr[n] <= i_memDataIn;
            end
         end
      end
   end

   // Zero-latency read mux over the register map; the step bit always
   // reads back as 0 and unlisted bits are 0.
   always_comb begin
      o_memDataOut = '0;
      case (i_memAddr)
         3'd0: o_memDataOut[5:0] = {bkptEnable, 1'b0, ovfEnable, o_doPause};
         3'd1: o_memDataOut[5:0] = {stickyOvf, haltIndex, haltCause};
         3'd2: o_memDataOut = setpoint;
         3'd3: o_memDataOut = pcByteAddr;
         3'd4: o_memDataOut = i_reportSP;
         3'd5: o_memDataOut = bkptAddr[0];
         3'd6: o_memDataOut = bkptAddr[1];
         3'd7: o_memDataOut = bkptAddr[2];
         default: o_memDataOut = '0;
      endcase
   end

endmodule

// File: tb/tb_core_debug_ctrl.sv
// Self-checking bench for core_debug_ctrl: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_core_debug_ctrl;

   localparam int DATA_W   = 16;
   localparam int NUM_BKPT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  memAddr;
   logic [15:0] memDataIn;
   logic        memWrEn;
   logic [15:0] memDataOut;
   logic [15:0] reportSP;
   logic [14:0] reportPC;
   logic        reportHLT;
   logic        reportRetire;
   logic        doPause;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [15:0] curSP;
   logic [14:0] curPC;
   logic        curHLT;
   logic        curRst;

   bit          mValid = 1'b0;
   bit          mPaused;
   bit          mStepping;
   bit          mOvfEn;
   bit          mSticky;
   bit          mSkip;
   bit          mBkEn [3];
   logic [15:0] mSet;
   logic [15:0] mBk [3];
   int          mCause;
   int          mIdx;

   core_debug_ctrl #(
      .DATA_W  (DATA_W),
      .NUM_BKPT(NUM_BKPT)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_memAddr     (memAddr),
      .i_memDataIn   (memDataIn),
      .i_memWrEn     (memWrEn),
      .o_memDataOut  (memDataOut),
      .i_reportSP    (reportSP),
      .i_reportPC    (reportPC),
      .i_reportHLT   (reportHLT),
      .i_reportRetire(reportRetire),
      .o_doPause     (doPause)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h at time %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic wr, input logic [2:0] a, input logic [15:0] d, input logic ret);
      @(negedge clk);
      memWrEn      = wr;
      memAddr      = a;
      memDataIn    = d;
      reportRetire = ret;
      reportSP     = curSP;
      reportPC     = curPC;
      reportHLT    = curHLT;
      rst          = curRst;
   endtask

   task automatic cycleCheck(input logic wr, input logic [2:0] a, input logic [15:0] d, input logic ret,
                             input logic expPause, input string name);
      applyStimulus(wr, a, d, ret);
      #1;
      checkOutput(name, 16'(doPause), 16'(expPause));
   endtask

   task automatic readCheck(input logic [2:0] a, input logic [15:0] expected, input logic expPause, input string name);
      applyStimulus(1'b0, a, 16'h0000, 1'b0);
      #1;
      checkOutput(name, memDataOut, expected);
      checkOutput({name, "_pause"}, 16'(doPause), 16'(expPause));
   endtask

   task automatic modelPause(input int cause, input int idx);
      mPaused   = 1'b1;
      mStepping = 1'b0;
      mCause    = cause;
      mIdx      = (cause == 4) ? idx : 0;
   endtask

   // Behavioural reference: one call per rising edge, using the inputs that
   // were held stable across that edge.
   task automatic modelAdvance();
      bit ovf;
      bit leaving;
      bit wrCtrl;
      int hitIdx;
      int cause;
      if (rst) begin
         mValid    = 1'b1;
         mPaused   = 1'b0;
         mStepping = 1'b0;
         mOvfEn    = 1'b0;
         mSticky   = 1'b0;
         mSkip     = 1'b0;
         mSet      = 16'h0000;
         mCause    = 0;
         mIdx      = 0;
         for (int n = 0; n < 3; n++) begin
            mBkEn[n] = 1'b0;
            mBk[n]   = 16'h0000;
         end
         return;
      end
      if (!mValid) return;
      ovf    = !mPaused && mOvfEn && (reportSP < mSet);
      hitIdx = -1;
      if (!mPaused && !mSkip) begin
         for (int n = 0; n < NUM_BKPT; n++) begin
            if (hitIdx < 0 && mBkEn[n] && (mBk[n] == {reportPC, 1'b0})) hitIdx = n;
         end
      end
      cause   = reportHLT ? 2 : (ovf ? 3 : ((hitIdx >= 0) ? 4 : 0));
      wrCtrl  = memWrEn && (memAddr == 3'd0);
      leaving = 1'b0;
      if (mStepping) begin
         if (cause != 0) modelPause(cause, hitIdx);
         else if (reportRetire) modelPause(5, 0);
      end else if (!mPaused) begin
         if (cause != 0) modelPause(cause, hitIdx);
         else if (wrCtrl && memDataIn[0]) modelPause(1, 0);
      end else if (!reportHLT && wrCtrl) begin
         if (memDataIn[2]) begin
            mPaused   = 1'b0;
            mStepping = 1'b1;
            leaving   = 1'b1;
         end else if (!memDataIn[0]) begin
            mPaused = 1'b0;
            leaving = 1'b1;
         end
      end
      if (leaving) mSkip = 1'b1;
      else if (reportRetire) mSkip = 1'b0;
      if (ovf) mSticky = 1'b1;
      else if (memWrEn && memAddr == 3'd1 && memDataIn[5]) mSticky = 1'b0;
      if (wrCtrl) begin
         mOvfEn = memDataIn[1];
         for (int n = 0; n < NUM_BKPT; n++) mBkEn[n] = memDataIn[3 + n];
      end
      if (memWrEn && memAddr == 3'd2) mSet = memDataIn;
      if (memWrEn && memAddr >= 3'd5 && (int'(memAddr) - 5) < NUM_BKPT) mBk[int'(memAddr) - 5] = memDataIn;
   endtask

   function automatic logic [15:0] expectedRead(input logic [2:0] a);
      int v;
      v = 0;
      case (a)
         3'd0: begin
            v = int'(mPaused) + 2 * int'(mOvfEn);
            for (int n = 0; n < 3; n++) v += int'(mBkEn[n]) << (3 + n);
         end
         3'd1: v = mCause + 8 * mIdx + 32 * int'(mSticky);
         3'd2: v = int'(mSet);
         3'd3: v = int'(reportPC) * 2;
         3'd4: v = int'(reportSP);
         default: v = int'(mBk[int'(a) - 5]);
      endcase
      return 16'(v);
   endfunction

   // Advance the reference model on every rising edge.
   always @(posedge clk) begin
      modelAdvance();
   end

   // Compare DUT outputs against the model every cycle, mid-way between edges.
   always @(negedge clk) begin
      #2;
      if (mValid) begin
         checkOutput("cycle_doPause", 16'(doPause), 16'(mPaused));
         checkOutput("cycle_readData", memDataOut, expectedRead(memAddr));
      end
   end

   // Directed scenarios first, then randomized traffic, then the summary.
   initial begin
      logic [2:0]  a;
      logic [15:0] d;
      logic        wr;
      logic        ret;

      curSP = 16'h1234;
      curPC = 15'h0ABC;
      curHLT = 1'b0;
      curRst = 1'b1;
      rst = 1'b1;
      memAddr = 3'd0;
      memDataIn = 16'h0000;
      memWrEn = 1'b0;
      reportSP = curSP;
      reportPC = curPC;
      reportHLT = 1'b0;
      reportRetire = 1'b0;

      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0);
      curRst = 1'b0;

      readCheck(3'd0, 16'h0000, 1'b0, "rst_ctrl");
      readCheck(3'd1, 16'h0000, 1'b0, "rst_status");
      readCheck(3'd2, 16'h0000, 1'b0, "rst_setpoint");
      readCheck(3'd3, 16'h1578, 1'b0, "rst_pc");
      readCheck(3'd4, 16'h1234, 1'b0, "rst_sp");
      readCheck(3'd5, 16'h0000, 1'b0, "rst_bkpt0");
      readCheck(3'd6, 16'h0000, 1'b0, "rst_bkpt1");
      readCheck(3'd7, 16'h0000, 1'b0, "rst_bkpt2");

      applyStimulus(1'b1, 3'd0, 16'h0038, 1'b0);
      readCheck(3'd0, 16'h0018, 1'b0, "ctrl_unused_bkpt_en");
      applyStimulus(1'b1, 3'd7, 16'h0040, 1'b0);
      readCheck(3'd7, 16'h0000, 1'b0, "bkpt2_ignored");
      applyStimulus(1'b1, 3'd0, 16'h0000, 1'b0);

      applyStimulus(1'b1, 3'd2, 16'h0100, 1'b0);
      applyStimulus(1'b1, 3'd0, 16'h0002, 1'b0);
      curSP = 16'h0100;
      readCheck(3'd0, 16'h0002, 1'b0, "sp_equal_setpoint");
      curSP = 16'h00FE;
      cycleCheck(1'b0, 3'd1, 16'h0000, 1'b0, 1'b0, "ovf_event_cycle");
      readCheck(3'd1, 16'h0023, 1'b1, "ovf_status");
      applyStimulus(1'b1, 3'd1, 16'h0020, 1'b0);
      readCheck(3'd1, 16'h0003, 1'b1, "sticky_cleared");
      readCheck(3'd0, 16'h0003, 1'b1, "ctrl_paused");
      curSP = 16'h0200;
      applyStimulus(1'b1, 3'd0, 16'h0000, 1'b0);
      readCheck(3'd0, 16'h0000, 1'b0, "resume_ovf");

      applyStimulus(1'b1, 3'd6, 16'h0040, 1'b0);
      applyStimulus(1'b1, 3'd0, 16'h0010, 1'b0);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b1);
      curPC = 15'h001E;
      cycleCheck(1'b0, 3'd3, 16'h0000, 1'b0, 1'b0, "pc_1e");
      curPC = 15'h001F;
      cycleCheck(1'b0, 3'd3, 16'h0000, 1'b0, 1'b0, "pc_1f");
      curPC = 15'h0020;
      cycleCheck(1'b0, 3'd3, 16'h0000, 1'b0, 1'b0, "pc_20_event");
      readCheck(3'd1, 16'h000C, 1'b1, "bkpt_status");
      applyStimulus(1'b1, 3'd0, 16'h0010, 1'b0);
      cycleCheck(1'b0, 3'd1, 16'h0000, 1'b0, 1'b0, "skip_1");
      cycleCheck(1'b0, 3'd1, 16'h0000, 1'b0, 1'b0, "skip_2");
      cycleCheck(1'b0, 3'd1, 16'h0000, 1'b1, 1'b0, "skip_retire");
      curPC = 15'h0021;
      cycleCheck(1'b0, 3'd1, 16'h0000, 1'b0, 1'b0, "pc_21");
      curPC = 15'h0020;
      cycleCheck(1'b0, 3'd1, 16'h0000, 1'b0, 1'b0, "pc_20_again");
      readCheck(3'd1, 16'h000C, 1'b1, "retrap_status");

      applyStimulus(1'b1, 3'd0, 16'h0004, 1'b0);
      cycleCheck(1'b0, 3'd1, 16'h0000, 1'b0, 1'b0, "step_1");
      cycleCheck(1'b0, 3'd1, 16'h0000, 1'b0, 1'b0, "step_2");
      cycleCheck(1'b0, 3'd1, 16'h0000, 1'b1, 1'b0, "step_retire");
      readCheck(3'd1, 16'h0005, 1'b1, "step_status");

      applyStimulus(1'b1, 3'd0, 16'h0002, 1'b0);
      curSP = 16'h0010;
      curHLT = 1'b1;
      cycleCheck(1'b0, 3'd1, 16'h0000, 1'b0, 1'b0, "hlt_ovf_event");
      readCheck(3'd1, 16'h0022, 1'b1, "hlt_ovf_status");
      applyStimulus(1'b1, 3'd0, 16'h0002, 1'b0);
      readCheck(3'd0, 16'h0003, 1'b1, "resume_blocked_by_hlt");
      curHLT = 1'b0;
      curSP = 16'h0200;

      applyStimulus(1'b1, 3'd0, 16'h0000, 1'b0);
      readCheck(3'd0, 16'h0000, 1'b0, "resume_after_hlt");
      applyStimulus(1'b1, 3'd0, 16'h0001, 1'b0);
      readCheck(3'd1, 16'h0021, 1'b1, "sw_pause_status");
      applyStimulus(1'b1, 3'd0, 16'h0004, 1'b0);
      cycleCheck(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, "in_step");
      curRst = 1'b1;
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0);
      curRst = 1'b0;
      readCheck(3'd0, 16'h0000, 1'b0, "post_rst_ctrl");
      readCheck(3'd1, 16'h0000, 1'b0, "post_rst_status");
      readCheck(3'd2, 16'h0000, 1'b0, "post_rst_setpoint");
      readCheck(3'd6, 16'h0000, 1'b0, "post_rst_bkpt1");

      for (int c = 0; c < 4000; c++) begin
         a  = 3'($urandom_range(0, 7));
         wr = ($urandom_range(0, 2) == 0);
         case (a)
            3'd0:    d = {10'($urandom), 6'($urandom_range(0, 63))};
            3'd2:    d = 16'($urandom_range(0, 80));
            3'd5, 3'd6, 3'd7: d = 16'($urandom_range(0, 15) * 2);
            default: d = 16'($urandom);
         endcase
         ret   = ($urandom_range(0, 3) == 0);
         curSP = 16'($urandom_range(0, 100));
         if ($urandom_range(0, 3) == 0) curPC = 15'($urandom_range(0, 15));
         if (curHLT) curHLT = ($urandom_range(0, 3) != 0);
         else curHLT = ($urandom_range(0, 39) == 0);
         curRst = ($urandom_range(0, 299) == 0);
         applyStimulus(wr, a, d, ret);
      end
      curRst = 1'b0;
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0);
      applyStimulus(1'b0, 3'd0, 16'h0000, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/core_debug_ctrl.md
# core_debug_ctrl

Parametrised memory-mapped control/status satellite for the uP core; the successor to the fixed 16-bit core control block. It exposes the core's PC and SP and owns the pause line. It adds real stack-overflow detection against a setpoint, up to three PC breakpoints, a single-step mode and a sticky halt-cause status register. It sits on the memory map beside the other map blocks and drives the core's pause input.

## Interface
Parameters:
- DATA_W, 16, data/address width of map registers; PC width is DATA_W-1.
- NUM_BKPT, 2, number of breakpoint registers, legal 1..3.

Ports:
- i_clk  in  1  core clock; single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_memAddr  in  3  register select within block.
- i_memDataIn  in  DATA_W  write data.
- i_memWrEn  in  1  write strobe, sampled on rising i_clk.
- o_memDataOut  out  DATA_W  read data, combinational from i_memAddr.
- i_reportSP  in  DATA_W  current stack pointer.
- i_reportPC  in  DATA_W-1  current PC (word address).
- i_reportHLT  in  1  core executed HLT (level).
- i_reportRetire  in  1  one-cycle pulse per retired instruction.
- o_doPause  out  1  core pause request.

## Operation
Register map (reads of unlisted bits = 0):
- 0 CTRL: [0] pause (reads o_doPause); [1] overflow enable; [2] step (write-only, reads 0); [3+n] breakpoint n enable.
- 1 STATUS: [2:0] cause (0 none, 1 sw pause, 2 HLT, 3 overflow, 4 breakpoint, 5 step done); [4:3] breakpoint index; [5] sticky overflow flag. Writing 1 to bit 5 clears it; other bits are read-only.
- 2 SETPOINT: overflow threshold.
- 3 PC: {i_reportPC, 1'b0}. 4 SP: i_reportSP. Both read-only.
- 5..7 BKPT0..2: byte-address breakpoints. Slots at or beyond NUM_BKPT read 0 and ignore writes.

State machine RUN / PAUSED / STEP; o_doPause = (state == PAUSED):
- RUN -> PAUSED on the highest-priority event in a cycle: HLT > overflow (enable set and i_reportSP < SETPOINT, unsigned; also sets sticky flag) > breakpoint (enabled n with BKPT[n] == {i_reportPC, 0}; lowest n wins) > CTRL write with pause=1 (cause 1). Cause and index are latched on entry.
- PAUSED -> RUN on a CTRL write with pause=0 and step=0.
- PAUSED -> STEP on a CTRL write with step=1; the pause bit is ignored for that write.
- STEP -> PAUSED on i_reportRetire (cause 5). HLT, overflow and breakpoint also apply in STEP with the same priority and take precedence over step-done.
- While i_reportHLT is high, PAUSED cannot be left; resume and step writes are ignored.
- Breakpoint skip: on leaving PAUSED, breakpoint matching is masked until the first i_reportRetire, so resuming at a breakpointed PC does not re-trap.
- A step bit written in RUN is ignored. An event in the same cycle as a CTRL write takes precedence over the write's pause bit; the write's enable bits still update.
- Overflow and breakpoint detection are inactive in PAUSED.

## Timing
- Reset: state RUN, o_doPause=0, CTRL/STATUS/SETPOINT/BKPT all 0, breakpoint mask clear.
- Writes take effect at the rising edge where i_memWrEn=1; the new value is readable the following cycle.
- Reads have zero latency (combinational mux).
- Event detection is combinational on the current-cycle inputs; o_doPause rises one clock after the event cycle.
- Resume: o_doPause falls one clock after the CTRL write.
- Step: o_doPause is low from the cycle after the write until the cycle after i_reportRetire.
- Reset asserted in any state returns to RUN on the next edge regardless of other inputs.

## Test plan
- Reset, then read addresses 0..7 -> all 0 except PC/SP echoes; o_doPause=0.
- SETPOINT=0x0100, CTRL=0x0002, drive SP 0x0100 then 0x00FE -> o_doPause high one cycle after 0x00FE; STATUS=0x0023. Write STATUS=0x0020 -> reads 0x0003.
- BKPT1=0x0040, CTRL=0x0010, PC walks 0x1E,0x1F,0x20 -> pause; STATUS=0x000C. CTRL=0x0010 -> resume, no re-trap at PC 0x20; after a retire, PC returning to 0x20 traps again.
- While PAUSED, write CTRL=0x0004 -> o_doPause low until retire pulse 3 cycles later, then high; STATUS cause=5.
- i_reportHLT and overflow in the same cycle -> cause=2, sticky set. A resume write while HLT is still high is ignored; o_doPause stays 1.
- Set CTRL pause in RUN, assert i_rst mid-STEP -> next cycle state RUN, all registers 0.
